// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings,
// arbiter state encoding and default bus widths.
package sdram_pkg;

    // Default widths for the W989DxDB interface
    localparam int ADDR_W_DEF = 13;
    localparam int BANK_W_DEF = 2;
    localparam int DQ_W_DEF   = 16;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Arbiter states; the bus owner is a pure function of the state
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARB   = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_bus_mux.sv
// Combinational SDRAM bus select: routes the owning sequencer's command,
// bank, address and write data to the pins according to the arbiter state.
module sdram_bus_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BANK_W = BANK_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  arb_state_t        state,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        ar_cmd,
    input  logic [BANK_W-1:0] ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    // Select command/bank/address; idle bus parks on NOP with all-ones address
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '1;
        sdram_addr = '1;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_bank = '1;
                sdram_addr = '1;
            end
        endcase
    end

    // Only the write sequencer may ever drive the DQ pad
    always_comb begin
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        if (state == ST_WRITE) begin
            sdram_dq_out = wr_dq;
            sdram_dq_oe  = wr_dq_oe;
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// SDRAM command arbiter: holds the bus on the init sequencer until init
// completes, then grants it to one sequencer at a time. Refresh has strict
// priority; write and read alternate when both are pending.
module sdram_arb
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BANK_W = BANK_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              ar_req,
    input  logic              ar_end,
    input  logic [3:0]        ar_cmd,
    input  logic [BANK_W-1:0] ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ar_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_t state_q;
    logic       last_wr_q;   // 1 when the most recent data grant was a write

    // Arbitration FSM; grants are never preempted, each op ends on its own *_end
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_end) state_q <= ST_ARB;
                end
                ST_ARB: begin
                    if (ar_req) begin
                        state_q <= ST_AREF;
                    end else if (wr_req && rd_req) begin
                        if (last_wr_q) begin
                            state_q   <= ST_READ;
                            last_wr_q <= 1'b0;
                        end else begin
                            state_q   <= ST_WRITE;
                            last_wr_q <= 1'b1;
                        end
                    end else if (wr_req) begin
                        state_q   <= ST_WRITE;
                        last_wr_q <= 1'b1;
                    end else if (rd_req) begin
                        state_q   <= ST_READ;
                        last_wr_q <= 1'b0;
                    end
                end
                ST_AREF: begin
                    if (ar_end) state_q <= ST_ARB;
                end
                ST_WRITE: begin
                    if (wr_end) state_q <= ST_ARB;
                end
                ST_READ: begin
                    if (rd_end) state_q <= ST_ARB;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Grants decode the state register so they drop with the async reset
    assign ar_en = (state_q == ST_AREF);
    assign wr_en = (state_q == ST_WRITE);
    assign rd_en = (state_q == ST_READ);

    sdram_bus_mux #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W),
        .DQ_W   (DQ_W)
    ) u_bus_mux (
        .state        (state_q),
        .init_cmd     (init_cmd),
        .init_bank    (init_bank),
        .init_addr    (init_addr),
        .ar_cmd       (ar_cmd),
        .ar_bank      (ar_bank),
        .ar_addr      (ar_addr),
        .wr_cmd       (wr_cmd),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_dq        (wr_dq),
        .wr_dq_oe     (wr_dq_oe),
        .rd_cmd       (rd_cmd),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .sdram_cmd    (sdram_cmd),
        .sdram_bank   (sdram_bank),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe)
    );

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: init hold-off, priority, round-robin,
// no-preemption, DQ routing and asynchronous reset mid-operation.
module tb_sdram_arb;

    logic        arb_clk = 1'b0;
    logic        arb_rst;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [12:0] init_addr;
    logic        init_end;
    logic        ar_req, ar_end;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank;
    logic [12:0] wr_addr;
    logic [15:0] wr_dq;
    logic        wr_dq_oe;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank;
    logic [12:0] rd_addr;
    logic        ar_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    int checks = 0;
    int errors = 0;

    sdram_arb dut (
        .arb_clk      (arb_clk),
        .arb_rst      (arb_rst),
        .init_cmd     (init_cmd),
        .init_bank    (init_bank),
        .init_addr    (init_addr),
        .init_end     (init_end),
        .ar_req       (ar_req),
        .ar_end       (ar_end),
        .ar_cmd       (ar_cmd),
        .ar_bank      (ar_bank),
        .ar_addr      (ar_addr),
        .wr_req       (wr_req),
        .wr_end       (wr_end),
        .wr_cmd       (wr_cmd),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_dq        (wr_dq),
        .wr_dq_oe     (wr_dq_oe),
        .rd_req       (rd_req),
        .rd_end       (rd_end),
        .rd_cmd       (rd_cmd),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .ar_en        (ar_en),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .sdram_cmd    (sdram_cmd),
        .sdram_bank   (sdram_bank),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe)
    );

    always #5 arb_clk = ~arb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Enables packed as {ar_en, wr_en, rd_en}
    task automatic chk_en(input string tag, input logic [2:0] exp);
        chk({tag, ".en"}, {29'd0, ar_en, wr_en, rd_en}, {29'd0, exp});
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] c,
                           input logic [1:0] b, input logic [12:0] a);
        chk({tag, ".cmd"},  {28'd0, sdram_cmd},  {28'd0, c});
        chk({tag, ".bank"}, {30'd0, sdram_bank}, {30'd0, b});
        chk({tag, ".addr"}, {19'd0, sdram_addr}, {19'd0, a});
    endtask

    task automatic chk_nop(input string tag);
        chk_en(tag, 3'b000);
        chk_bus(tag, 4'b0111, 2'b11, 13'h1FFF);
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge arb_clk);
        #1;
    endtask

    initial begin
        arb_rst   = 1'b1;
        init_cmd  = 4'b0010; init_bank = 2'b01; init_addr = 13'h0400;
        ar_cmd    = 4'b0001; ar_bank   = 2'b10; ar_addr   = 13'h00AA;
        wr_cmd    = 4'b0100; wr_bank   = 2'b11; wr_addr   = 13'h0123;
        rd_cmd    = 4'b0101; rd_bank   = 2'b01; rd_addr   = 13'h0456;
        wr_dq     = 16'h0000; wr_dq_oe = 1'b0;
        init_end  = 1'b0;
        ar_req = 1'b1; ar_end = 1'b0;
        wr_req = 1'b1; wr_end = 1'b0;
        rd_req = 1'b1; rd_end = 1'b0;

        // Reset state: bus follows init inputs, no grants, DQ quiet
        #12;
        chk_en("reset", 3'b000);
        chk_bus("reset", 4'b0010, 2'b01, 13'h0400);
        chk("reset.dq_out", {16'd0, sdram_dq_out}, 32'd0);
        chk("reset.dq_oe",  {31'd0, sdram_dq_oe},  32'd0);

        // Requests ignored while init incomplete
        @(negedge arb_clk);
        arb_rst = 1'b0;
        step();
        step();
        chk_en("init_hold", 3'b000);
        chk_bus("init_hold", 4'b0010, 2'b01, 13'h0400);

        // init_end -> ARB, then refresh wins over write and read
        init_end = 1'b1;
        step();
        chk_nop("arb0");
        step();
        chk_en("ar_grant", 3'b100);
        chk_bus("ar_grant", 4'b0001, 2'b10, 13'h00AA);
        ar_req = 1'b0;
        step();
        chk_en("ar_hold", 3'b100);
        ar_end = 1'b1;
        step();
        ar_end = 1'b0;
        chk_nop("ar_release");

        // Both data requests pending, last_wr reset 0 -> write first
        step();
        chk_en("wr_grant", 3'b010);
        chk_bus("wr_grant", 4'b0100, 2'b11, 13'h0123);
        wr_req = 1'b0;
        wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
        #1;
        chk("wr.dq_out", {16'd0, sdram_dq_out}, 32'h0000A5A5);
        chk("wr.dq_oe",  {31'd0, sdram_dq_oe},  32'd1);

        // Foreign rd_end ignored; refresh arriving mid-write waits
        rd_end = 1'b1;
        ar_req = 1'b1;
        step();
        rd_end = 1'b0;
        chk_en("wr_ignore_rd_end", 3'b010);
        step();
        chk_en("wr_no_preempt", 3'b010);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_nop("wr_release");
        chk("arb.dq_oe",  {31'd0, sdram_dq_oe},  32'd0);
        chk("arb.dq_out", {16'd0, sdram_dq_out}, 32'd0);

        // Refresh ahead of the pending read
        step();
        chk_en("ar_before_rd", 3'b100);
        ar_req = 1'b0;
        ar_end = 1'b1;
        step();
        ar_end = 1'b0;
        chk_nop("ar2_release");
        step();
        chk_en("rd_grant", 3'b001);
        chk_bus("rd_grant", 4'b0101, 2'b01, 13'h0456);
        chk("rd.dq_oe", {31'd0, sdram_dq_oe}, 32'd0);

        // init_end falling is ignored; held wr/rd requests alternate
        init_end = 1'b0;
        wr_req = 1'b1;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_nop("rr_nop0");
        step();
        chk_en("rr_wr1", 3'b010);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_nop("rr_nop1");
        step();
        chk_en("rr_rd1", 3'b001);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_nop("rr_nop2");
        step();
        chk_en("rr_wr2", 3'b010);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();
        chk_en("rr_rd2", 3'b001);

        // Async reset mid-read drops the grant without a clock edge
        init_end = 1'b1;
        #2;
        arb_rst = 1'b1;
        #1;
        chk_en("rst_mid_rd", 3'b000);
        chk_bus("rst_mid_rd", 4'b0010, 2'b01, 13'h0400);
        step();
        chk_en("rst_held", 3'b000);
        @(negedge arb_clk);
        arb_rst = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        chk_nop("post_rst_arb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
